// File: rtl/bsr_chain_param_if.sv
// Boundary-scan chain bus: serial scan, TAP-style enables, mode select and
// the pin/core parallel paths. The tester side is the master, the chain is
// the slave.
//
// When BSR_SHIFT_CNT_EN is defined the bus also carries the shift counter
// (shift_cnt) and its over-shift flag (shift_ovf).
//
// Signalling: there is no valid/ready handshake. capture_dr, shift_dr and
// update_dr are level enables sampled on every rising CK edge. Each edge
// where an enable is high performs exactly one capture, shift or update.
interface bsr_chain_param_if #(
   parameter int NUM_IN  = 36,
   parameter int NUM_OUT = 38
`ifdef BSR_SHIFT_CNT_EN
   ,
   parameter int CNT_W   = 8
`endif
);
   logic               TDI;
   logic               TDO;
   logic               capture_dr;
   logic               shift_dr;
   logic               update_dr;
   logic [1:0]         mode;
   logic [NUM_IN-1:0]  pin_in;
   logic [NUM_IN-1:0]  core_in;
   logic [NUM_OUT-1:0] core_out;
   logic [NUM_OUT-1:0] pin_out;
`ifdef BSR_SHIFT_CNT_EN
   logic [CNT_W-1:0]   shift_cnt;
   logic               shift_ovf;
`endif

   modport master (
      output TDI, capture_dr, shift_dr, update_dr, mode, pin_in, core_out,
      input  TDO, core_in, pin_out
`ifdef BSR_SHIFT_CNT_EN
      , input shift_cnt, shift_ovf
`endif
   );

   modport slave (
      input  TDI, capture_dr, shift_dr, update_dr, mode, pin_in, core_out,
      output TDO, core_in, pin_out
`ifdef BSR_SHIFT_CNT_EN
      , output shift_cnt, shift_ovf
`endif
   );
endinterface

// File: rtl/bsr_chain_param.sv
// Parametrised boundary-scan register chain wrapping a core.
// Chain order: TDI -> in cells 0..NUM_IN-1 -> out cells 0..NUM_OUT-1 -> TDO.
// Every cell has a shift stage (sh_q) and an update stage (upd_q). Bit 0 of
// each vector is the cell nearest TDI.
// Sequencing of capture/shift/update is done by an external controller.
// Optional macro BSR_SHIFT_CNT_EN adds a saturating shift counter and a
// sticky over-shift flag.
module bsr_chain_param #(
   parameter int                 NUM_IN      = 36,
   parameter int                 NUM_OUT     = 38,
   parameter logic [NUM_OUT-1:0] RST_UPD_OUT = {NUM_OUT{1'b0}}
`ifdef BSR_SHIFT_CNT_EN
   ,
   parameter int                 CNT_W       = 8
`endif
) (
   input logic              CK,
   input logic              RST_N,
   bsr_chain_param_if.slave bus
);

   localparam int L = NUM_IN + NUM_OUT;

   localparam logic [1:0] MODE_FUNC   = 2'd0;
   localparam logic [1:0] MODE_SAMPLE = 2'd1;
   localparam logic [1:0] MODE_EXTEST = 2'd2;
   localparam logic [1:0] MODE_INTEST = 2'd3;

   // The input half of the update stage resets to 0. The output half resets
   // to the safe pin state.
   localparam logic [L-1:0] UPD_RST = {RST_UPD_OUT, {NUM_IN{1'b0}}};

   logic [L-1:0] sh_q, sh_d;
   logic [L-1:0] upd_q, upd_d;

   // Shift stage next state: shift beats capture; otherwise hold.
   always_comb begin
      sh_d = sh_q;
      if (bus.shift_dr) begin
         sh_d = {sh_q[L-2:0], bus.TDI};
      end else if (bus.capture_dr) begin
         sh_d = {bus.core_out, bus.pin_in};
      end
   end

   // Update stage loads the shift stage as it was before this edge.
   always_comb begin
      upd_d = upd_q;
      if (bus.update_dr) begin
         upd_d = sh_q;
      end
   end

   // Chain registers; reset overrides every enable.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         sh_q  <= '0;
         upd_q <= UPD_RST;
      end else begin
         sh_q  <= sh_d;
         upd_q <= upd_d;
      end
   end

   assign bus.TDO = sh_q[L-1];

   // Zero-latency routing. FUNC and SAMPLE are transparent. Only INTEST drives
   // the core from the chain. EXTEST and INTEST both drive the pins.
   always_comb begin
      bus.core_in = bus.pin_in;
      bus.pin_out = bus.core_out;
      if (bus.mode == MODE_INTEST) begin
         bus.core_in = upd_q[NUM_IN-1:0];
      end
      if (bus.mode == MODE_EXTEST || bus.mode == MODE_INTEST) begin
         bus.pin_out = upd_q[L-1:NUM_IN];
      end
   end

`ifdef BSR_SHIFT_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Counter next state: clear on capture, saturating count on shift. The
   // flag is sticky once the count passes the chain length.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus.shift_dr) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         ovf_d = ovf_q | (32'(cnt_d) > 32'(L));
      end else if (bus.capture_dr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   // Counter registers.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.shift_cnt = cnt_q;
   assign bus.shift_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bsr_chain_param.sv
// Testbench for bsr_chain_param with a 4-in / 4-out chain. A queue-based
// chain model is checked against the DUT on every falling edge. Hand-computed
// literal expectations pin both the model and the DUT.
module tb_bsr_chain_param;

   localparam int NI = 4;
   localparam int NO = 4;
   localparam int L  = NI + NO;
   localparam logic [NO-1:0] RST_OUT = 4'b1010;
`ifdef BSR_SHIFT_CNT_EN
   localparam int CW = 8;
`endif

   // ---------------- clock / reset ----------------
   logic ck;
   logic rst_n;

   initial ck = 1'b0;
   always #5 ck = ~ck;

   bsr_chain_param_if #(
      .NUM_IN (NI),
      .NUM_OUT(NO)
`ifdef BSR_SHIFT_CNT_EN
      , .CNT_W(CW)
`endif
   ) bus ();

   bsr_chain_param #(
      .NUM_IN     (NI),
      .NUM_OUT    (NO),
      .RST_UPD_OUT(RST_OUT)
`ifdef BSR_SHIFT_CNT_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .CK   (ck),
      .RST_N(rst_n),
      .bus  (bus)
   );

   // ---------------- counters ----------------
   int vec_cnt = 0;
   int err_cnt = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- chain model ----------------
   // m_sh[k] and m_upd[k] are chain position k, where 0 is nearest TDI.
   bit m_sh[$];
   bit m_upd[$];
   int m_cnt;
   bit m_ovf;

   function automatic void model_reset();
      m_sh.delete();
      m_upd.delete();
      for (int k = 0; k < L; k++) begin
         m_sh.push_back(1'b0);
         m_upd.push_back(k >= NI ? RST_OUT[k-NI] : 1'b0);
      end
      m_cnt = 0;
      m_ovf = 1'b0;
   endfunction

   function automatic void model_edge(input bit rn, input bit tdi, input bit cap,
                                      input bit sft, input bit upd,
                                      input logic [NI-1:0] pins,
                                      input logic [NO-1:0] cout);
      bit old_sh[$];
      if (!rn) begin
         model_reset();
         return;
      end
      old_sh = m_sh;
      if (sft) begin
         m_sh.push_front(tdi);
         void'(m_sh.pop_back());
         if (m_cnt < 255) m_cnt++;
         if (m_cnt > L) m_ovf = 1'b1;
      end else if (cap) begin
         for (int i = 0; i < NI; i++) m_sh[i] = pins[i];
         for (int j = 0; j < NO; j++) m_sh[NI+j] = cout[j];
         m_cnt = 0;
         m_ovf = 1'b0;
      end
      if (upd) m_upd = old_sh;
   endfunction

   // ---------------- driver ----------------
   task automatic step(input bit rn, input bit tdi, input bit cap, input bit sft, input bit upd);
      rst_n          = rn;
      bus.TDI        = tdi;
      bus.capture_dr = cap;
      bus.shift_dr   = sft;
      bus.update_dr  = upd;
      @(posedge ck);
      model_edge(rn, tdi, cap, sft, upd, bus.pin_in, bus.core_out);
      #1;
   endtask

   // ---------------- compare process ----------------
   always @(negedge ck) begin
      if (chk_en) begin
         logic [NI-1:0] exp_ci;
         logic [NO-1:0] exp_po;
         for (int i = 0; i < NI; i++)
            exp_ci[i] = (bus.mode == 2'd3) ? m_upd[i] : bus.pin_in[i];
         for (int j = 0; j < NO; j++)
            exp_po[j] = (bus.mode >= 2'd2) ? m_upd[NI+j] : bus.core_out[j];
         check("model_tdo", 32'(bus.TDO), 32'(m_sh[L-1]));
         check("model_core_in", 32'(bus.core_in), 32'(exp_ci));
         check("model_pin_out", 32'(bus.pin_out), 32'(exp_po));
`ifdef BSR_SHIFT_CNT_EN
         check("model_shift_cnt", 32'(bus.shift_cnt), 32'(m_cnt));
         check("model_shift_ovf", 32'(bus.shift_ovf), 32'(m_ovf));
`endif
      end
   end

   // ---------------- stimulus ----------------
   int tdo_seq[8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
   int shift_in[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

   initial begin
      model_reset();
      rst_n          = 1'b0;
      bus.TDI        = 1'b0;
      bus.capture_dr = 1'b0;
      bus.shift_dr   = 1'b0;
      bus.update_dr  = 1'b0;
      bus.mode       = 2'd2;
      bus.pin_in     = 4'h6;
      bus.core_out   = 4'h9;

      // Reset state, with EXTEST selected.
      step(0, 0, 0, 0, 0);
      chk_en = 1'b1;
      step(0, 0, 0, 0, 0);
      check("rst_pin_out", 32'(bus.pin_out), 32'h A);
      check("rst_tdo", 32'(bus.TDO), 32'h0);
      check("rst_core_in", 32'(bus.core_in), 32'h6);

      // Shift 1,0,1,1,0,0,1,0 and then update. The first bit travels
      // farthest, to out cell 3.
      foreach (shift_in[k]) step(1, shift_in[k][0], 0, 1, 0);
      step(1, 0, 0, 0, 1);
      check("shift_upd_pin_out", 32'(bus.pin_out), 32'b1011);
      check("shift_upd_core_in", 32'(bus.core_in), 32'h6);
      bus.mode = 2'd3;
      #1;
      check("shift_upd_intest_core_in", 32'(bus.core_in), 32'b0010);
      bus.mode = 2'd2;

      // Capture, then unload: out cell 3..0 followed by in cell 3..0.
      bus.pin_in   = 4'hC;
      bus.core_out = 4'h3;
      step(1, 0, 1, 0, 0);
      check("cap_tdo_0", 32'(bus.TDO), 32'(tdo_seq[0]));
      for (int k = 1; k < 8; k++) begin
         step(1, 0, 0, 1, 0);
         check($sformatf("cap_tdo_%0d", k), 32'(bus.TDO), 32'(tdo_seq[k]));
      end

      // Shift and update on the same edge: the update stage takes the
      // pre-shift contents.
      step(1, 0, 1, 0, 0);
      step(1, 1, 0, 1, 1);
      check("shift_and_upd", 32'(bus.pin_out), 32'h3);
      // Shift and capture on the same edge: shift wins, capture is ignored.
      bus.core_out = 4'h5;
      step(1, 0, 1, 1, 0);
      step(1, 0, 0, 0, 1);
      check("shift_beats_cap", 32'(bus.pin_out), 32'hF);

      // INTEST: the core sees the update stage regardless of the pins.
      bus.pin_in = 4'h5;
      step(1, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1);
      bus.mode   = 2'd3;
      bus.pin_in = 4'hA;
      #1;
      check("intest_core_in", 32'(bus.core_in), 32'h5);
      step(1, 0, 0, 0, 0);

      // FUNC and SAMPLE are transparent.
      bus.mode     = 2'd0;
      bus.pin_in   = 4'h9;
      bus.core_out = 4'h6;
      #1;
      check("func_core_in", 32'(bus.core_in), 32'h9);
      check("func_pin_out", 32'(bus.pin_out), 32'h6);
      step(1, 1, 0, 1, 0);
      bus.mode     = 2'd1;
      bus.pin_in   = 4'h3;
      bus.core_out = 4'hC;
      step(1, 0, 1, 0, 0);
      check("sample_pin_out", 32'(bus.pin_out), 32'hC);
      step(1, 1, 0, 1, 1);
      step(1, 0, 0, 0, 1);

      // Reset mid-shift: enables are ignored and the pins go to the safe
      // state.
      bus.mode = 2'd2;
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 1);
      step(0, 1, 1, 1, 1);
      check("rst_mid_pin_out", 32'(bus.pin_out), 32'h A);
      check("rst_mid_tdo", 32'(bus.TDO), 32'h0);
      step(1, 0, 0, 0, 0);

`ifdef BSR_SHIFT_CNT_EN
      // Shift counter and over-shift flag.
      step(1, 0, 1, 0, 0);
      for (int k = 0; k < 8; k++) step(1, 1, 0, 1, 0);
      check("cnt_at_len", 32'(bus.shift_cnt), 32'd8);
      check("ovf_at_len", 32'(bus.shift_ovf), 32'd0);
      step(1, 1, 0, 1, 0);
      check("cnt_over", 32'(bus.shift_cnt), 32'd9);
      check("ovf_over", 32'(bus.shift_ovf), 32'd1);
      step(1, 0, 1, 0, 0);
      check("cnt_clr", 32'(bus.shift_cnt), 32'd0);
      check("ovf_clr", 32'(bus.shift_ovf), 32'd0);
      for (int k = 0; k < 300; k++) step(1, k[0], 0, 1, 0);
      check("cnt_sat", 32'(bus.shift_cnt), 32'd255);
      check("ovf_sat", 32'(bus.shift_ovf), 32'd1);
`endif

      @(negedge ck);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
